// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD sector arbiter:
//   - SECTOR_AW        : sector address width (26 bits)
//   - OP_READ/OP_WRITE : SD controller op codes
//   - sd_state_t       : arbiter FSM state encoding
//   - select_byte()    : one-hot byte selector used for the outgoing write path
// -----------------------------------------------------------------------------
package sd_pkg;

  localparam int SECTOR_AW = 26;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_ACTIVE     = 3'd3,
    ST_RELEASE    = 3'd4
  } sd_state_t;

  // Picks the byte of the requester named by a one-hot grant; zero when no grant.
  function automatic logic [7:0] select_byte(input logic [1:0] sel,
                                             input logic [7:0] b0,
                                             input logic [7:0] b1);
    logic [7:0] r;
    case (sel)
      2'b01:   r = b0;
      2'b10:   r = b1;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sd_sector_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin picker. The winner is combinational from req and the
// priority pointer; the pointer moves past the winner when load is asserted.
// After reset requester 0 has priority.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req  [1:0] : request vector
//   load       : accept the current winner (advance pointer)
//   winner[1:0]: one-hot winner, 0 when no request
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       load,
  output logic [1:0] winner
);

  // Index of the requester that wins a tie next time.
  logic prio_r;

  // Winner selection: a lone requester always wins, a tie goes to prio_r.
  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = prio_r ? 2'b10 : 2'b01;
      default: winner = 2'b00;
    endcase
  end

  // Priority pointer: the winner drops to lowest priority once accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= 1'b0;
    end else if (load && (winner != 2'b00)) begin
      prio_r <= winner[0];
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// -----------------------------------------------------------------------------
// sd_sector_arbiter
// Shares one SD controller between two sector-level requesters. A request is
// granted round-robin, the op/sector are latched at grant, the controller is
// started once the card is ready, byte completions are strobed back to the
// owner and a one-cycle done closes the transaction.
//
// Build option: define SD_ARB_TIMEOUT_EN to enable an abort counter that forces
// completion TIMEOUT_CYCLES cycles after sd_execute and sets sticky
// timeout_err. Without it ACTIVE waits indefinitely and timeout_err is 0.
//
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   req[1:0], req_op[1:0]              : per-requester request level / op code
//   req_sector0/1[25:0]                : per-requester sector address
//   wr_byte0/1[7:0]                    : per-requester outgoing write byte
//   grant[1:0]                         : one-hot owner, 0 when idle
//   byte_stb[1:0], done[1:0]           : one-cycle byte / sector pulses to owner
//   rd_byte[7:0]                       : last byte read from the card
//   sd_op_code, sd_execute             : controller op and start pulse
//   sd_sector_address[25:0]            : latched sector address
//   sd_outgoing_byte[7:0]              : owner's write byte (combinational)
//   sd_incoming_byte, sd_finished_byte,
//   sd_finished_sector, sd_busy        : controller status inputs
//   timeout_err                        : sticky abort flag
// -----------------------------------------------------------------------------
module sd_sector_arbiter
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [1:0]           req_op,
  input  logic [SECTOR_AW-1:0] req_sector0,
  input  logic [SECTOR_AW-1:0] req_sector1,
  input  logic [7:0]           wr_byte0,
  input  logic [7:0]           wr_byte1,
  output logic [1:0]           grant,
  output logic [1:0]           byte_stb,
  output logic [7:0]           rd_byte,
  output logic [1:0]           done,
  output logic                 sd_op_code,
  output logic                 sd_execute,
  output logic [SECTOR_AW-1:0] sd_sector_address,
  output logic [7:0]           sd_outgoing_byte,
  input  logic [7:0]           sd_incoming_byte,
  input  logic                 sd_finished_byte,
  input  logic                 sd_finished_sector,
  input  logic                 sd_busy,
  output logic                 timeout_err
);

  // The counter starts at 1 in the first ACTIVE cycle, so it needs at least 2.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  sd_state_t state_r;
  sd_state_t next_state_s;

  logic       fin_byte_d_r;
  logic       fin_sector_d_r;
  logic       byte_rise_s;
  logic       sector_rise_s;
  logic [1:0] winner_s;
  logic       pick_s;
  logic       timeout_hit_s;
  logic [1:0] grant_nxt_s;
  logic [1:0] done_nxt_s;
  logic [1:0] byte_stb_nxt_s;
  logic       execute_nxt_s;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .load   (pick_s),
    .winner (winner_s)
  );

  // Arbitration only happens from IDLE, so RELEASE can never re-grant.
  assign pick_s        = (state_r == ST_IDLE) && (req != 2'b00);
  assign byte_rise_s   = sd_finished_byte & ~fin_byte_d_r;
  assign sector_rise_s = sd_finished_sector & ~fin_sector_d_r;

  // Delayed copies of the controller completion levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_byte_d_r   <= 1'b0;
      fin_sector_d_r <= 1'b0;
    end else begin
      fin_byte_d_r   <= sd_finished_byte;
      fin_sector_d_r <= sd_finished_sector;
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TCW-1:0] tcnt_r;
  logic           terr_r;

  // Abort counter: cycles elapsed since the ISSUE cycle (ISSUE itself is 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_r <= '0;
    end else if (state_r == ST_ISSUE) begin
      tcnt_r <= TCW'(1);
    end else if (state_r == ST_ACTIVE) begin
      tcnt_r <= tcnt_r + TCW'(1);
    end else begin
      tcnt_r <= tcnt_r;
    end
  end

  assign timeout_hit_s = (state_r == ST_ACTIVE) && (tcnt_r == TCW'(TIMEOUT_CYCLES - 1));

  // Sticky error: a sector that finishes on the deadline cycle is not an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      terr_r <= 1'b0;
    end else if (timeout_hit_s && !sector_rise_s) begin
      terr_r <= 1'b1;
    end else begin
      terr_r <= terr_r;
    end
  end

  assign timeout_err = terr_r;
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_s) next_state_s = ST_WAIT_READY;
        else        next_state_s = ST_IDLE;
      end
      ST_WAIT_READY: begin
        if (!sd_busy) next_state_s = ST_ISSUE;
        else          next_state_s = ST_WAIT_READY;
      end
      ST_ISSUE: next_state_s = ST_ACTIVE;
      ST_ACTIVE: begin
        if (sector_rise_s || timeout_hit_s) next_state_s = ST_RELEASE;
        else                                next_state_s = ST_ACTIVE;
      end
      ST_RELEASE: next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered handshake outputs.
  always_comb begin
    grant_nxt_s    = grant;
    done_nxt_s     = 2'b00;
    byte_stb_nxt_s = 2'b00;
    execute_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_s) grant_nxt_s = winner_s;
        else        grant_nxt_s = 2'b00;
      end
      ST_RELEASE: grant_nxt_s = 2'b00;
      default:    grant_nxt_s = grant;
    endcase
    if (next_state_s == ST_ISSUE) execute_nxt_s = 1'b1;
    else                          execute_nxt_s = 1'b0;
    // A byte edge coincident with the sector edge still strobes.
    if ((state_r == ST_ACTIVE) && byte_rise_s) byte_stb_nxt_s = grant;
    else                                       byte_stb_nxt_s = 2'b00;
    if ((state_r == ST_ACTIVE) && (next_state_s == ST_RELEASE)) done_nxt_s = grant;
    else                                                         done_nxt_s = 2'b00;
  end

  // Registered handshake outputs; reset drops grant without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= 2'b00;
      done       <= 2'b00;
      byte_stb   <= 2'b00;
      sd_execute <= 1'b0;
    end else begin
      grant      <= grant_nxt_s;
      done       <= done_nxt_s;
      byte_stb   <= byte_stb_nxt_s;
      sd_execute <= execute_nxt_s;
    end
  end

  // Op and sector are captured from the winner at grant and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_op_code        <= OP_READ;
      sd_sector_address <= '0;
    end else if (pick_s) begin
      sd_op_code        <= winner_s[1] ? req_op[1] : req_op[0];
      sd_sector_address <= winner_s[1] ? req_sector1 : req_sector0;
    end else begin
      sd_op_code        <= sd_op_code;
      sd_sector_address <= sd_sector_address;
    end
  end

  // Read data capture, aligned with the byte strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_byte <= 8'h00;
    end else if ((state_r == ST_ACTIVE) && byte_rise_s) begin
      rd_byte <= sd_incoming_byte;
    end else begin
      rd_byte <= rd_byte;
    end
  end

  // Outgoing write byte follows the current owner with no register stage.
  always_comb begin
    sd_outgoing_byte = select_byte(grant, wr_byte0, wr_byte1);
  end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sd_sector_arbiter
// Directed self-checking bench for sd_sector_arbiter. Inputs are driven and
// outputs sampled on the falling clock edge; the design acts on the rising edge.
// The timeout scenario is selected by SD_ARB_TIMEOUT_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_sd_sector_arbiter;
  import sd_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           req;
  logic [1:0]           req_op;
  logic [SECTOR_AW-1:0] req_sector0;
  logic [SECTOR_AW-1:0] req_sector1;
  logic [7:0]           wr_byte0;
  logic [7:0]           wr_byte1;
  logic [1:0]           grant;
  logic [1:0]           byte_stb;
  logic [7:0]           rd_byte;
  logic [1:0]           done;
  logic                 sd_op_code;
  logic                 sd_execute;
  logic [SECTOR_AW-1:0] sd_sector_address;
  logic [7:0]           sd_outgoing_byte;
  logic [7:0]           sd_incoming_byte;
  logic                 sd_finished_byte;
  logic                 sd_finished_sector;
  logic                 sd_busy;
  logic                 timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sd_sector_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req                (req),
    .req_op             (req_op),
    .req_sector0        (req_sector0),
    .req_sector1        (req_sector1),
    .wr_byte0           (wr_byte0),
    .wr_byte1           (wr_byte1),
    .grant              (grant),
    .byte_stb           (byte_stb),
    .rd_byte            (rd_byte),
    .done               (done),
    .sd_op_code         (sd_op_code),
    .sd_execute         (sd_execute),
    .sd_sector_address  (sd_sector_address),
    .sd_outgoing_byte   (sd_outgoing_byte),
    .sd_incoming_byte   (sd_incoming_byte),
    .sd_finished_byte   (sd_finished_byte),
    .sd_finished_sector (sd_finished_sector),
    .sd_busy            (sd_busy),
    .timeout_err        (timeout_err)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    step();
    tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL reset_grant: got %b want 00", grant); end
    tests_run++; if (done !== 2'b00) begin tests_failed++; $display("FAIL reset_done: got %b want 00", done); end
    tests_run++; if (byte_stb !== 2'b00) begin tests_failed++; $display("FAIL reset_byte_stb: got %b want 00", byte_stb); end
    tests_run++; if (sd_execute !== 1'b0) begin tests_failed++; $display("FAIL reset_execute: got %b want 0", sd_execute); end
    tests_run++; if (sd_op_code !== 1'b0) begin tests_failed++; $display("FAIL reset_op_code: got %b want 0", sd_op_code); end
    tests_run++; if (sd_sector_address !== 26'h0) begin tests_failed++; $display("FAIL reset_sector: got %h want 0", sd_sector_address); end
    tests_run++; if (rd_byte !== 8'h00) begin tests_failed++; $display("FAIL reset_rd_byte: got %h want 00", rd_byte); end
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    tests_run++; if (sd_outgoing_byte !== 8'h00) begin tests_failed++; $display("FAIL reset_outgoing: got %h want 00", sd_outgoing_byte); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_grant();
    req_sector0 = 26'h1234567;
    req_op      = 2'b00;
    sd_busy     = 1'b0;
    req         = 2'b01;
    step();
    tests_run++; if (grant !== 2'b01) begin tests_failed++; $display("FAIL single_grant: got %b want 01", grant); end
    tests_run++; if (sd_sector_address !== 26'h1234567) begin tests_failed++; $display("FAIL single_sector: got %h want 1234567", sd_sector_address); end
    tests_run++; if (sd_execute !== 1'b0) begin tests_failed++; $display("FAIL single_exec_early: got %b want 0", sd_execute); end
    step();
    tests_run++; if (sd_execute !== 1'b1) begin tests_failed++; $display("FAIL single_exec: got %b want 1", sd_execute); end
    step();
    tests_run++; if (sd_execute !== 1'b0) begin tests_failed++; $display("FAIL single_exec_width: got %b want 0", sd_execute); end
    sd_finished_sector = 1'b1;
    step();
    tests_run++; if (done !== 2'b01) begin tests_failed++; $display("FAIL single_done: got %b want 01", done); end
    tests_run++; if (grant !== 2'b01) begin tests_failed++; $display("FAIL single_grant_in_release: got %b want 01", grant); end
    sd_finished_sector = 1'b0;
    req = 2'b00;
    step();
    tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL single_release_grant: got %b want 00", grant); end
    tests_run++; if (done !== 2'b00) begin tests_failed++; $display("FAIL single_done_width: got %b want 00", done); end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    req_sector0 = 26'h0000AAA;
    req_sector1 = 26'h3FFFFFF;
    req = 2'b11;
    step();
    tests_run++; if (grant !== 2'b01) begin tests_failed++; $display("FAIL rr_first: got %b want 01", grant); end
    tests_run++; if (sd_sector_address !== 26'h0000AAA) begin tests_failed++; $display("FAIL rr_first_sector: got %h want 0000aaa", sd_sector_address); end
    step(); step();
    sd_finished_sector = 1'b1;
    step();
    tests_run++; if (done !== 2'b01) begin tests_failed++; $display("FAIL rr_first_done: got %b want 01", done); end
    sd_finished_sector = 1'b0;
    step();
    tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL rr_no_regrant_release: got %b want 00", grant); end
    step();
    tests_run++; if (grant !== 2'b10) begin tests_failed++; $display("FAIL rr_second: got %b want 10", grant); end
    tests_run++; if (sd_sector_address !== 26'h3FFFFFF) begin tests_failed++; $display("FAIL rr_second_sector: got %h want 3ffffff", sd_sector_address); end
    step(); step();
    sd_finished_sector = 1'b1;
    step();
    tests_run++; if (done !== 2'b10) begin tests_failed++; $display("FAIL rr_second_done: got %b want 10", done); end
    sd_finished_sector = 1'b0;
    step(); step();
    tests_run++; if (grant !== 2'b01) begin tests_failed++; $display("FAIL rr_third: got %b want 01", grant); end
    step(); step();
    sd_finished_sector = 1'b1;
    step();
    sd_finished_sector = 1'b0;
    req = 2'b00;
    step();
    tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL rr_idle: got %b want 00", grant); end
  endtask

  task automatic test_busy_wait();
    int exec_seen = 0;
    int grant_bad = 0;
    sd_busy = 1'b1;
    req     = 2'b10;
    step();
    tests_run++; if (grant !== 2'b10) begin tests_failed++; $display("FAIL busy_grant: got %b want 10", grant); end
    for (int i = 0; i < 500; i++) begin
      step();
      if (sd_execute !== 1'b0) exec_seen++;
      if (grant !== 2'b10) grant_bad++;
    end
    tests_run++; if (exec_seen !== 0) begin tests_failed++; $display("FAIL busy_no_exec: got %0d pulses want 0", exec_seen); end
    tests_run++; if (grant_bad !== 0) begin tests_failed++; $display("FAIL busy_grant_held: got %0d bad cycles want 0", grant_bad); end
    sd_busy = 1'b0;
    step();
    tests_run++; if (sd_execute !== 1'b1) begin tests_failed++; $display("FAIL busy_exec_after: got %b want 1", sd_execute); end
    step();
    sd_finished_sector = 1'b1;
    step();
    tests_run++; if (done !== 2'b10) begin tests_failed++; $display("FAIL busy_done: got %b want 10", done); end
    sd_finished_sector = 1'b0;
    req = 2'b00;
    step();
  endtask

  task automatic test_read_sector();
    int       stb_cnt  = 0;
    int       rd_bad   = 0;
    int       dbl      = 0;
    int       done_cnt = 0;
    logic [1:0] last_stb;
    logic [1:0] last_done;
    logic [7:0] exp_b;
    req_op = 2'b00;
    req    = 2'b01;
    step();
    tests_run++; if (sd_op_code !== OP_READ) begin tests_failed++; $display("FAIL read_op_code: got %b want 0", sd_op_code); end
    step(); step();
    for (int i = 0; i < 512; i++) begin
      exp_b = 8'(i);
      sd_incoming_byte = exp_b;
      sd_finished_byte = 1'b1;
      if (i == 511) sd_finished_sector = 1'b1;
      step();
      if (byte_stb === 2'b01) stb_cnt++;
      if (rd_byte !== exp_b) rd_bad++;
      if (done !== 2'b00) done_cnt++;
      last_stb  = byte_stb;
      last_done = done;
      if (i == 511) req = 2'b00;
      if ((i % 64) == 0) begin
        // Held level must not strobe twice.
        step();
        if (byte_stb !== 2'b00) dbl++;
        if (done !== 2'b00) done_cnt++;
      end
      sd_finished_byte   = 1'b0;
      sd_finished_sector = 1'b0;
      step();
      if (byte_stb !== 2'b00) dbl++;
      if (done !== 2'b00) done_cnt++;
    end
    tests_run++; if (stb_cnt !== 512) begin tests_failed++; $display("FAIL read_stb_count: got %0d want 512", stb_cnt); end
    tests_run++; if (rd_bad !== 0) begin tests_failed++; $display("FAIL read_rd_byte: got %0d mismatching bytes want 0", rd_bad); end
    tests_run++; if (dbl !== 0) begin tests_failed++; $display("FAIL read_double_strobe: got %0d extra strobes want 0", dbl); end
    tests_run++; if (done_cnt !== 1) begin tests_failed++; $display("FAIL read_done_count: got %0d want 1", done_cnt); end
    tests_run++; if (last_stb !== 2'b01) begin tests_failed++; $display("FAIL read_final_stb: got %b want 01", last_stb); end
    tests_run++; if (last_done !== 2'b01) begin tests_failed++; $display("FAIL read_final_done: got %b want 01", last_done); end
    sd_incoming_byte = 8'h5C;
    sd_finished_byte = 1'b1;
    step();
    tests_run++; if (byte_stb !== 2'b00) begin tests_failed++; $display("FAIL idle_strobe_ignored: got %b want 00", byte_stb); end
    sd_finished_byte = 1'b0;
    step();
    tests_run++; if (rd_byte !== 8'hFF) begin tests_failed++; $display("FAIL idle_rd_byte_held: got %h want ff", rd_byte); end
  endtask

  task automatic test_write_and_drop();
    wr_byte0    = 8'hA5;
    wr_byte1    = 8'h3C;
    req_op      = 2'b10;
    req_sector1 = 26'h2A55A5A;
    step();
    tests_run++; if (sd_outgoing_byte !== 8'h00) begin tests_failed++; $display("FAIL write_idle_outgoing: got %h want 00", sd_outgoing_byte); end
    req = 2'b10;
    step();
    tests_run++; if (grant !== 2'b10) begin tests_failed++; $display("FAIL write_grant: got %b want 10", grant); end
    tests_run++; if (sd_op_code !== OP_WRITE) begin tests_failed++; $display("FAIL write_op_code: got %b want 1", sd_op_code); end
    tests_run++; if (sd_outgoing_byte !== 8'h3C) begin tests_failed++; $display("FAIL write_outgoing: got %h want 3c", sd_outgoing_byte); end
    wr_byte1 = 8'h5A;
    #1;
    tests_run++; if (sd_outgoing_byte !== 8'h5A) begin tests_failed++; $display("FAIL write_outgoing_comb: got %h want 5a", sd_outgoing_byte); end
    req         = 2'b00;
    req_op      = 2'b00;
    req_sector1 = 26'h0;
    step();
    tests_run++; if (sd_execute !== 1'b1) begin tests_failed++; $display("FAIL drop_exec: got %b want 1", sd_execute); end
    tests_run++; if (sd_sector_address !== 26'h2A55A5A) begin tests_failed++; $display("FAIL drop_sector_held: got %h want 2a55a5a", sd_sector_address); end
    tests_run++; if (sd_op_code !== OP_WRITE) begin tests_failed++; $display("FAIL drop_op_held: got %b want 1", sd_op_code); end
    step();
    sd_finished_sector = 1'b1;
    step();
    tests_run++; if (done !== 2'b10) begin tests_failed++; $display("FAIL drop_done: got %b want 10", done); end
    sd_finished_sector = 1'b0;
    step();
    tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL drop_release: got %b want 00", grant); end
  endtask

  task automatic test_reset_mid_op();
    req = 2'b01;
    step(); step(); step();
    tests_run++; if (grant !== 2'b01) begin tests_failed++; $display("FAIL rst_mid_pre_grant: got %b want 01", grant); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL rst_mid_grant_drop: got %b want 00", grant); end
    step();
    tests_run++; if (done !== 2'b00) begin tests_failed++; $display("FAIL rst_mid_no_done: got %b want 00", done); end
    rst_n = 1'b1;
    step();
    tests_run++; if (grant !== 2'b01) begin tests_failed++; $display("FAIL rst_mid_regrant: got %b want 01", grant); end
    step(); step();
    sd_finished_sector = 1'b1;
    step();
    tests_run++; if (done !== 2'b01) begin tests_failed++; $display("FAIL rst_mid_done: got %b want 01", done); end
    sd_finished_sector = 1'b0;
    req = 2'b00;
    step();
  endtask

`ifdef SD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k     = 0;
    bit found = 1'b0;
    req = 2'b01;
    step(); step();
    while ((k < 200) && !found) begin
      step();
      k++;
      if (done !== 2'b00) found = 1'b1;
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL timeout_done_seen: got none within 200 cycles want done"); end
    tests_run++; if (k !== 64) begin tests_failed++; $display("FAIL timeout_latency: got %0d want 64", k); end
    tests_run++; if (done !== 2'b01) begin tests_failed++; $display("FAIL timeout_done_owner: got %b want 01", done); end
    tests_run++; if (timeout_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_err_set: got %b want 1", timeout_err); end
    req = 2'b00;
    step(); step(); step();
    tests_run++; if (timeout_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_err_sticky: got %b want 1", timeout_err); end
    tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("FAIL timeout_release: got %b want 00", grant); end
  endtask
`else
  task automatic test_timeout();
    int done_seen = 0;
    int grant_bad = 0;
    int err_seen  = 0;
    req = 2'b01;
    step(); step(); step();
    for (int i = 0; i < 300; i++) begin
      step();
      if (done !== 2'b00) done_seen++;
      if (grant !== 2'b01) grant_bad++;
      if (timeout_err !== 1'b0) err_seen++;
    end
    tests_run++; if (done_seen !== 0) begin tests_failed++; $display("FAIL notimeout_done: got %0d pulses want 0", done_seen); end
    tests_run++; if (grant_bad !== 0) begin tests_failed++; $display("FAIL notimeout_grant: got %0d bad cycles want 0", grant_bad); end
    tests_run++; if (err_seen !== 0) begin tests_failed++; $display("FAIL notimeout_err: got %0d cycles set want 0", err_seen); end
    sd_finished_sector = 1'b1;
    step();
    tests_run++; if (done !== 2'b01) begin tests_failed++; $display("FAIL notimeout_late_done: got %b want 01", done); end
    sd_finished_sector = 1'b0;
    req = 2'b00;
    step();
  endtask
`endif

  initial begin
    rst_n              = 1'b0;
    req                = 2'b00;
    req_op             = 2'b00;
    req_sector0        = 26'h0;
    req_sector1        = 26'h0;
    wr_byte0           = 8'h00;
    wr_byte1           = 8'h00;
    sd_incoming_byte   = 8'h00;
    sd_finished_byte   = 1'b0;
    sd_finished_sector = 1'b0;
    sd_busy            = 1'b0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_busy_wait();
    test_read_sector();
    test_write_and_drop();
    test_reset_mid_op();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
